// File: rtl/clk_freq_checker.sv
//-----------------------------------------------------------------------------
// clk_freq_checker
//
// Purpose:
//   Periodically samples a synchronized 24-bit clock-count level and compares
//   it with an inclusive [iCNT_MIN, iCNT_MAX] window. It drives a debounced
//   lock/loss state machine and keeps a saturating count of out-of-window
//   samples. Software reads a lock bit and an error count instead of polling
//   raw counts.
//
// Parameters:
//   SAMPLE_PERIOD - clk cycles between samples of iCLK_CNT
//   LOCK_CNT      - consecutive in-window samples to declare lock (1..15)
//   UNLOCK_CNT    - consecutive out-of-window samples to declare loss (1..15)
//
// Ports:
//   clk           in   reference clock, the only clock
//   rst_n         in   asynchronous active-low reset
//   iENABLE       in   checker enable; low forces IDLE and clears the timer
//   iCLR          in   single-cycle pulse; clears error count and trackers
//   iCLK_CNT      in   [23:0] synchronized count level from the sampler
//   iCNT_MIN      in   [23:0] inclusive lower bound
//   iCNT_MAX      in   [23:0] inclusive upper bound
//   oLOCKED       out  high while in LOCKED
//   oLOSS         out  one-cycle pulse on LOCKED -> LOST
//   oCLK_DEAD     out  last sample was exactly zero
//   oERR_CNT      out  [15:0] saturating count of out-of-window samples
//   oSTATE        out  [1:0] IDLE=0, ACQUIRE=1, LOCKED=2, LOST=3
//   oCNT_MIN_SEEN out  [23:0] smallest sample since clear
//   oCNT_MAX_SEEN out  [23:0] largest sample since clear
//
// Configuration macro:
//   CLK_FREQ_CHK_MINMAX_EN - when defined, min/max tracker registers are
//   built. When undefined, oCNT_MIN_SEEN is tied to 24'hFFFFFF and
//   oCNT_MAX_SEEN is tied to 0.
//-----------------------------------------------------------------------------
module clk_freq_checker #(
    parameter int SAMPLE_PERIOD = 1973800,
    parameter int LOCK_CNT      = 3,
    parameter int UNLOCK_CNT    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        iENABLE,
    input  logic        iCLR,
    input  logic [23:0] iCLK_CNT,
    input  logic [23:0] iCNT_MIN,
    input  logic [23:0] iCNT_MAX,
    output logic        oLOCKED,
    output logic        oLOSS,
    output logic        oCLK_DEAD,
    output logic [15:0] oERR_CNT,
    output logic [1:0]  oSTATE,
    output logic [23:0] oCNT_MIN_SEEN,
    output logic [23:0] oCNT_MAX_SEEN
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2,
        LOST    = 2'd3
    } state_t;

    localparam int TIMER_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(SAMPLE_PERIOD - 1);
    localparam logic [3:0]  LOCK_RUN   = 4'(LOCK_CNT);
    localparam logic [3:0]  UNLOCK_RUN = 4'(UNLOCK_CNT);
    localparam logic [15:0] ERR_MAX    = 16'hFFFF;

    state_t             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [3:0]         run_q, run_d;
    logic               locked_q, locked_d;
    logic               loss_q, loss_d;
    logic               dead_q, dead_d;
    logic [15:0]        errCnt_q, errCnt_d;

    logic               tick;
    logic               inWin;
    logic [3:0]         runInc;

    // The timer only runs once the FSM has left IDLE, so the first sample
    // lands a full SAMPLE_PERIOD after the entry cycle.
    assign tick   = iENABLE && (state_q != IDLE) && (timer_q == TIMER_LAST);
    assign inWin  = (iCLK_CNT >= iCNT_MIN) && (iCLK_CNT <= iCNT_MAX);
    assign runInc = run_q + 4'd1;

    // Next-state logic: enable has priority over everything, sampling
    // decisions happen only on tick, and a clear pulse always wins over an
    // error increment in the same cycle.
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        run_d    = run_q;
        loss_d   = 1'b0;
        dead_d   = dead_q;
        errCnt_d = errCnt_q;

        if (!iENABLE) begin
            state_d = IDLE;
            timer_d = '0;
            run_d   = 4'd0;
        end else if (state_q == IDLE) begin
            state_d = ACQUIRE;
            timer_d = '0;
            run_d   = 4'd0;
        end else begin
            timer_d = tick ? '0 : timer_q + TIMER_W'(1);
            if (tick) begin
                dead_d = (iCLK_CNT == 24'd0);
                if (!inWin && (errCnt_q != ERR_MAX)) begin
                    errCnt_d = errCnt_q + 16'd1;
                end
                case (state_q)
                    ACQUIRE, LOST: begin
                        if (inWin) begin
                            if (runInc == LOCK_RUN) begin
                                state_d = LOCKED;
                                run_d   = 4'd0;
                            end else begin
                                run_d = runInc;
                            end
                        end else begin
                            run_d = 4'd0;
                        end
                    end
                    LOCKED: begin
                        if (!inWin) begin
                            if (runInc == UNLOCK_RUN) begin
                                state_d = LOST;
                                run_d   = 4'd0;
                                loss_d  = 1'b1;
                            end else begin
                                run_d = runInc;
                            end
                        end else begin
                            run_d = 4'd0;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end

        if (iCLR) begin
            errCnt_d = 16'd0;
        end
    end

    // Lock flag is registered from the next state so oLOCKED comes straight
    // off a flop rather than a decode of the state register.
    assign locked_d = (state_d == LOCKED);

    // State and statistics registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            run_q    <= 4'd0;
            locked_q <= 1'b0;
            loss_q   <= 1'b0;
            dead_q   <= 1'b0;
            errCnt_q <= 16'd0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            run_q    <= run_d;
            locked_q <= locked_d;
            loss_q   <= loss_d;
            dead_q   <= dead_d;
            errCnt_q <= errCnt_d;
        end
    end

    assign oLOCKED   = locked_q;
    assign oLOSS     = loss_q;
    assign oCLK_DEAD = dead_q;
    assign oERR_CNT  = errCnt_q;
    assign oSTATE    = state_q;

`ifdef CLK_FREQ_CHK_MINMAX_EN
    logic [23:0] minSeen_q, minSeen_d;
    logic [23:0] maxSeen_q, maxSeen_d;

    // Extremes follow every sample taken outside IDLE; a clear restores the
    // empty-set values so the first later sample sets both trackers.
    always_comb begin
        minSeen_d = minSeen_q;
        maxSeen_d = maxSeen_q;
        if (tick) begin
            if (iCLK_CNT < minSeen_q) begin
                minSeen_d = iCLK_CNT;
            end
            if (iCLK_CNT > maxSeen_q) begin
                maxSeen_d = iCLK_CNT;
            end
        end
        if (iCLR) begin
            minSeen_d = 24'hFFFFFF;
            maxSeen_d = 24'h000000;
        end
    end

    // Tracker registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            minSeen_q <= 24'hFFFFFF;
            maxSeen_q <= 24'h000000;
        end else begin
            minSeen_q <= minSeen_d;
            maxSeen_q <= maxSeen_d;
        end
    end

    assign oCNT_MIN_SEEN = minSeen_q;
    assign oCNT_MAX_SEEN = maxSeen_q;
`else
    assign oCNT_MIN_SEEN = 24'hFFFFFF;
    assign oCNT_MAX_SEEN = 24'h000000;
`endif

endmodule

// File: tb/tb_clk_freq_checker.sv
//-----------------------------------------------------------------------------
// tb_clk_freq_checker
//
// Scoreboard bench for clk_freq_checker. The stimulus process advances a
// sample-level reference model on every clock edge and queues the expected
// output vector after each sample and the cycle following it; a monitor
// process pops and compares on the falling edge. A second instance with a
// one-cycle sample period drives the error counter into saturation in
// parallel with the main run.
//-----------------------------------------------------------------------------
module tb_clk_freq_checker;

   localparam int P      = 16;
   localparam int LOCK   = 3;
   localparam int UNLOCK = 2;
`ifdef CLK_FREQ_CHK_MINMAX_EN
   localparam bit MINMAX = 1'b1;
`else
   localparam bit MINMAX = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic        clr;
   logic [23:0] clkCnt;
   logic [23:0] cntMin;
   logic [23:0] cntMax;
   logic        oLOCKED;
   logic        oLOSS;
   logic        oCLK_DEAD;
   logic [15:0] oERR_CNT;
   logic [1:0]  oSTATE;
   logic [23:0] oCNT_MIN_SEEN;
   logic [23:0] oCNT_MAX_SEEN;

   logic        satRstN;
   logic        satEnable;
   logic        satClr;
   logic [23:0] satCnt;
   logic [23:0] satMin;
   logic [23:0] satMax;
   logic        satLocked;
   logic        satLoss;
   logic        satDead;
   logic [15:0] satErr;
   logic [1:0]  satState;
   logic [23:0] satMinSeen;
   logic [23:0] satMaxSeen;
   bit          satDone = 1'b0;

   int checks   = 0;
   int failures = 0;

   // Reference model state, at the level of samples and streaks.
   int          mState;
   int          mActive;
   int          mStreak;
   bit          mLoss;
   bit          mDead;
   int          mErr;
   logic [23:0] mMin;
   logic [23:0] mMax;
   bit          prevTick;
   bit          tickSeen;

   typedef struct {
      string       tag;
      logic [68:0] exp;
   } sbEntry_t;

   sbEntry_t sbQ[$];

   clk_freq_checker #(
      .SAMPLE_PERIOD(P),
      .LOCK_CNT(LOCK),
      .UNLOCK_CNT(UNLOCK)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .iENABLE(enable),
      .iCLR(clr),
      .iCLK_CNT(clkCnt),
      .iCNT_MIN(cntMin),
      .iCNT_MAX(cntMax),
      .oLOCKED(oLOCKED),
      .oLOSS(oLOSS),
      .oCLK_DEAD(oCLK_DEAD),
      .oERR_CNT(oERR_CNT),
      .oSTATE(oSTATE),
      .oCNT_MIN_SEEN(oCNT_MIN_SEEN),
      .oCNT_MAX_SEEN(oCNT_MAX_SEEN)
   );

   clk_freq_checker #(
      .SAMPLE_PERIOD(1),
      .LOCK_CNT(LOCK),
      .UNLOCK_CNT(UNLOCK)
   ) satDut (
      .clk(clk),
      .rst_n(satRstN),
      .iENABLE(satEnable),
      .iCLR(satClr),
      .iCLK_CNT(satCnt),
      .iCNT_MIN(satMin),
      .iCNT_MAX(satMax),
      .oLOCKED(satLocked),
      .oLOSS(satLoss),
      .oCLK_DEAD(satDead),
      .oERR_CNT(satErr),
      .oSTATE(satState),
      .oCNT_MIN_SEEN(satMinSeen),
      .oCNT_MAX_SEEN(satMaxSeen)
   );

   // 10 ns reference clock.
   always #5 clk = ~clk;

   // Single comparison point; every check funnels through here.
   task automatic checkOutput(input string tag, input logic [68:0] act, input logic [68:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: actual=%h required=%h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic void modelReset();
      mState   = 0;
      mActive  = 0;
      mStreak  = 0;
      mLoss    = 1'b0;
      mDead    = 1'b0;
      mErr     = 0;
      mMin     = 24'hFFFFFF;
      mMax     = 24'h000000;
      prevTick = 1'b0;
   endfunction

   // One clock edge of behaviour, using the inputs present at that edge.
   function automatic bit modelEdge();
      bit tick;
      bit inWin;
      tick = 1'b0;
      if (!rst_n) begin
         modelReset();
         return 1'b0;
      end
      mLoss = 1'b0;
      if (!enable) begin
         mState  = 0;
         mActive = 0;
         mStreak = 0;
      end else if (mState == 0) begin
         mState  = 1;
         mActive = 0;
         mStreak = 0;
      end else begin
         mActive++;
         tick = ((mActive % P) == 0);
         if (tick) begin
            inWin = (clkCnt >= cntMin) && (clkCnt <= cntMax);
            mDead = (clkCnt == 24'd0);
            if (!inWin && mErr < 65535) mErr++;
            if (MINMAX && clkCnt < mMin) mMin = clkCnt;
            if (MINMAX && clkCnt > mMax) mMax = clkCnt;
            if (mState == 2) begin
               if (inWin) mStreak = 0;
               else begin
                  mStreak++;
                  if (mStreak == UNLOCK) begin
                     mState  = 3;
                     mStreak = 0;
                     mLoss   = 1'b1;
                  end
               end
            end else begin
               if (inWin) begin
                  mStreak++;
                  if (mStreak == LOCK) begin
                     mState  = 2;
                     mStreak = 0;
                  end
               end else mStreak = 0;
            end
         end
      end
      if (clr) begin
         mErr = 0;
         mMin = 24'hFFFFFF;
         mMax = 24'h000000;
      end
      return tick;
   endfunction

   function automatic void pushExpect(input string tag);
      sbEntry_t e;
      e.tag = tag;
      e.exp = {(mState == 2), mLoss, mDead, 16'(mErr), 2'(mState), mMin, mMax};
      sbQ.push_back(e);
   endfunction

   // Advance one clock edge and queue expectations around each sample.
   task automatic applyStimulus(input string tag, input bit forceCheck);
      bit tick;
      @(posedge clk);
      #1;
      tick = modelEdge();
      if (tick || prevTick || forceCheck) pushExpect(tag);
      prevTick = tick;
      tickSeen = tick;
   endtask

   task automatic runTicks(input string tag, input int n);
      int seen;
      seen = 0;
      for (int k = 0; k < n * (P + 4) && seen < n; k++) begin
         applyStimulus(tag, 1'b0);
         if (tickSeen) seen++;
      end
   endtask

   // Monitor: compare every queued expectation on the falling edge.
   initial begin : monitorProc
      sbEntry_t e;
      forever begin
         @(negedge clk);
         while (sbQ.size() > 0) begin
            e = sbQ.pop_front();
            checkOutput(e.tag, {oLOCKED, oLOSS, oCLK_DEAD, oERR_CNT, oSTATE,
                                oCNT_MIN_SEEN, oCNT_MAX_SEEN}, e.exp);
         end
      end
   end

   // Saturation run on the one-cycle-period instance: every edge in
   // ACQUIRE is an out-of-window sample.
   initial begin : satProc
      satRstN   = 1'b0;
      satEnable = 1'b0;
      satClr    = 1'b0;
      satCnt    = 24'd250;
      satMin    = 24'd300;
      satMax    = 24'd200;
      repeat (2) @(posedge clk);
      #1;
      satRstN   = 1'b1;
      satEnable = 1'b1;
      @(posedge clk);
      repeat (65534) @(posedge clk);
      #1;
      checkOutput("satBelowMax", 69'(satErr), 69'(16'hFFFE));
      @(posedge clk);
      #1;
      checkOutput("satReachMax", 69'(satErr), 69'(16'hFFFF));
      repeat (5) @(posedge clk);
      #1;
      checkOutput("satHold", 69'(satErr), 69'(16'hFFFF));
      checkOutput("satState", 69'(satState), 69'(2'd1));
      satClr = 1'b1;
      @(posedge clk);
      #1;
      satClr = 1'b0;
      checkOutput("satClrWins", 69'(satErr), 69'(0));
      @(posedge clk);
      #1;
      checkOutput("satAfterClr", 69'(satErr), 69'(1));
      satDone = 1'b1;
   end

   // Main stimulus: directed scenarios followed by a randomized run.
   initial begin : stimProc
      int roll;
      rst_n  = 1'b0;
      enable = 1'b0;
      clr    = 1'b0;
      clkCnt = 24'd0;
      cntMin = 24'd100;
      cntMax = 24'd200;
      modelReset();
      pushExpect("resetState");
      repeat (2) applyStimulus("resetHold", 1'b1);
      rst_n = 1'b1;

      $display("[TB] lock latency");
      clkCnt = 24'd150;
      enable = 1'b1;
      repeat (48) applyStimulus("lockLatency", 1'b1);
      checkOutput("lockedBefore49", 69'(oLOCKED), 69'(0));
      applyStimulus("lockLatency", 1'b1);
      checkOutput("lockedAt49", 69'(oLOCKED), 69'(1));
      checkOutput("errAfterLock", 69'(oERR_CNT), 69'(0));

      $display("[TB] loss of lock");
      clkCnt = 24'd201;
      runTicks("lossRun", 2);
      checkOutput("lostState", 69'(oSTATE), 69'(2'd3));
      checkOutput("lossPulse", 69'(oLOSS), 69'(1));
      checkOutput("lossErr", 69'(oERR_CNT), 69'(2));
      applyStimulus("lossEnd", 1'b1);
      checkOutput("lossPulseEnds", 69'(oLOSS), 69'(0));

      $display("[TB] relock and single glitch");
      clkCnt = 24'd150;
      runTicks("relock", 3);
      checkOutput("relocked", 69'(oSTATE), 69'(2'd2));
      clr = 1'b1;
      applyStimulus("clrPulse", 1'b1);
      clr = 1'b0;
      checkOutput("clrErr", 69'(oERR_CNT), 69'(0));
      clkCnt = 24'd201;
      runTicks("glitch", 1);
      clkCnt = 24'd150;
      runTicks("glitchRecover", 1);
      checkOutput("glitchStaysLocked", 69'(oSTATE), 69'(2'd2));
      checkOutput("glitchErr", 69'(oERR_CNT), 69'(1));

      $display("[TB] window boundaries");
      clkCnt = 24'd100;
      runTicks("lowEdge", 1);
      clkCnt = 24'd200;
      runTicks("highEdge", 1);
      checkOutput("edgesInWindow", 69'(oERR_CNT), 69'(1));
      clkCnt = 24'd99;
      runTicks("belowMin", 1);
      checkOutput("belowMinErr", 69'(oERR_CNT), 69'(2));
      clkCnt = 24'd150;
      runTicks("backIn", 1);

      $display("[TB] dead clock");
      clkCnt = 24'd0;
      runTicks("dead", 1);
      checkOutput("deadFlag", 69'(oCLK_DEAD), 69'(1));
      checkOutput("deadErr", 69'(oERR_CNT), 69'(3));
      clkCnt = 24'd150;
      runTicks("alive", 1);
      checkOutput("aliveFlag", 69'(oCLK_DEAD), 69'(0));

      $display("[TB] clear on error tick");
      clkCnt = 24'd99;
      while (((mActive + 1) % P) != 0) applyStimulus("preClr", 1'b0);
      clr = 1'b1;
      applyStimulus("clrOnTick", 1'b1);
      clr = 1'b0;
      checkOutput("clrBeatsErr", 69'(oERR_CNT), 69'(0));
      clkCnt = 24'd150;
      runTicks("postClr", 1);

      $display("[TB] min/max trackers");
      clr = 1'b1;
      applyStimulus("trackClr", 1'b1);
      clr = 1'b0;
      clkCnt = 24'd120;
      runTicks("track", 1);
      clkCnt = 24'd180;
      runTicks("track", 1);
      clkCnt = 24'd110;
      runTicks("track", 1);
      checkOutput("minSeen", 69'(oCNT_MIN_SEEN), 69'(MINMAX ? 24'd110 : 24'hFFFFFF));
      checkOutput("maxSeen", 69'(oCNT_MAX_SEEN), 69'(MINMAX ? 24'd180 : 24'd0));

      $display("[TB] inverted window");
      cntMin = 24'd300;
      cntMax = 24'd200;
      clkCnt = 24'd250;
      enable = 1'b0;
      applyStimulus("disable", 1'b1);
      enable = 1'b1;
      runTicks("inverted", 5);
      checkOutput("neverLocks", 69'(oSTATE), 69'(2'd1));
      checkOutput("invertedErr", 69'(oERR_CNT), 69'(5));

      $display("[TB] asynchronous reset mid-acquire");
      cntMin = 24'd100;
      cntMax = 24'd200;
      clkCnt = 24'd150;
      runTicks("preReset", 1);
      repeat (3) applyStimulus("preReset", 1'b0);
      #2;
      rst_n = 1'b0;
      modelReset();
      pushExpect("asyncReset");
      #1;
      checkOutput("asyncResetState", 69'(oSTATE), 69'(2'd0));
      checkOutput("asyncResetErr", 69'(oERR_CNT), 69'(0));
      repeat (2) applyStimulus("resetHold", 1'b1);
      rst_n = 1'b1;

      $display("[TB] randomized run");
      for (int i = 0; i < 1000; i++) begin
         roll = int'($urandom_range(0, 99));
         if (roll < 4) begin
            cntMin = 24'($urandom_range(50, 150));
            cntMax = (roll == 0) ? cntMin - 24'd10 : cntMin + 24'($urandom_range(0, 100));
         end else if (roll < 6) begin
            enable = 1'b0;
            repeat ($urandom_range(1, 3)) applyStimulus("randIdle", 1'b1);
            enable = 1'b1;
         end else if (roll < 9) begin
            clr = 1'b1;
            applyStimulus("randClr", 1'b1);
            clr = 1'b0;
         end
         roll = int'($urandom_range(0, 99));
         if (roll < 65) clkCnt = 24'($urandom_range(cntMin, cntMax));
         else if (roll < 75) clkCnt = cntMin - 24'd1;
         else if (roll < 85) clkCnt = cntMax + 24'd1;
         else if (roll < 92) clkCnt = 24'd0;
         else clkCnt = 24'($urandom);
         runTicks("random", 1);
      end

      @(negedge clk);
      #1;
      wait (satDone);
      @(negedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/clk_freq_checker.md
# clk_freq_checker

Consumer of a clock-count sampler's output: periodically samples the synchronized 24-bit clock-count level, compares it against a programmable inclusive window, and drives a debounced lock/loss state plus error statistics. Sits in the 50 MHz housekeeping domain beside each SERDES pattern generator/checker, so software reads a lock bit and error count instead of polling raw counts.

## Interface
- SAMPLE_PERIOD, 1973800 — clk cycles between samples of iCLK_CNT; must exceed sampler window plus sync latency
- LOCK_CNT, 3 — consecutive in-window samples required to declare lock (1..15)
- UNLOCK_CNT, 2 — consecutive out-of-window samples required to declare loss (1..15)
- clk  input  1  50 MHz reference clock; the block's only clock
- rst_n  input  1  asynchronous, active-low reset
- iENABLE  input  1  checker enable; low forces IDLE and holds timer at 0
- iCLR  input  1  single-cycle pulse; clears oERR_CNT and min/max trackers
- iCLK_CNT  input  24  synchronized count level from the sampler
- iCNT_MIN  input  24  inclusive lower bound (static register)
- iCNT_MAX  input  24  inclusive upper bound (static register)
- oLOCKED  output  1  high in LOCKED state
- oLOSS  output  1  one-cycle pulse on LOCKED→LOST transition
- oCLK_DEAD  output  1  last sample was exactly 0
- oERR_CNT  output  16  saturating count of out-of-window samples
- oSTATE  output  2  IDLE=0, ACQUIRE=1, LOCKED=2, LOST=3
- oCNT_MIN_SEEN  output  24  smallest sample since clear (macro-dependent)
- oCNT_MAX_SEEN  output  24  largest sample since clear (macro-dependent)

## Operation
- Timer counts 0..SAMPLE_PERIOD-1 while iENABLE; `tick` asserts on terminal value, timer wraps to 0.
- On tick: in_win = (iCNT_MIN <= iCLK_CNT <= iCNT_MAX), unsigned, inclusive both ends. iCNT_MIN > iCNT_MAX ⇒ every sample out of window.
- Run counter (4 bits) counts consecutive agreeing samples; reset to 0 on disagreement or state change.
- FSM transitions (evaluated only on tick, except enable):
  - IDLE: iENABLE rising → ACQUIRE, run=0. First sample is taken at the first tick after entry.
  - ACQUIRE: in_win increments run; run reaching LOCK_CNT → LOCKED. Out of window → run=0, stay.
  - LOCKED: out-of-window increments run; run reaching UNLOCK_CNT → LOST, oLOSS pulses. In-window sample → run=0.
  - LOST: behaves as ACQUIRE (LOCK_CNT in-window → LOCKED); no repeat oLOSS.
  - Any state, iENABLE low → IDLE next cycle, timer=0, run=0; oERR_CNT and trackers retained.
- oERR_CNT increments on each out-of-window tick in any non-IDLE state; saturates at 0xFFFF.
- oCLK_DEAD updates on every tick (1 if iCLK_CNT==0, else 0); a 0 sample also counts as out of window when iCNT_MIN>0.
- iCLR and an error tick in the same cycle: clear wins, oERR_CNT=0.

## Timing
- All outputs registered; FSM, oERR_CNT, oCLK_DEAD, oLOSS update the cycle after tick.
- Reset values: oLOCKED=0, oLOSS=0, oCLK_DEAD=0, oERR_CNT=0, oSTATE=IDLE, oCNT_MIN_SEEN=0xFFFFFF, oCNT_MAX_SEEN=0, timer=0.
- Reset mid-operation: all state returns to reset values immediately (asynchronous); operation resumes at first iENABLE-high cycle after rst_n deasserts.
- Minimum lock latency from enable: LOCK_CNT×SAMPLE_PERIOD+1 cycles.
- iCLK_CNT sampled only on tick; changes between ticks are ignored.

## Configuration
- CLK_FREQ_CHK_MINMAX_EN defined: oCNT_MIN_SEEN/oCNT_MAX_SEEN track extremes of every non-IDLE tick sample; iCLR restores 0xFFFFFF/0.
- Not defined: no tracker registers; oCNT_MIN_SEEN ties to 0xFFFFFF and oCNT_MAX_SEEN to 0 constantly.

## Test plan
- SAMPLE_PERIOD=16, LOCK_CNT=3, window 100..200, iCLK_CNT=150, enable → oLOCKED rises 49 cycles after enable, oERR_CNT=0.
- Locked, iCLK_CNT=201 for 2 ticks → oSTATE=LOST, one oLOSS pulse, oERR_CNT=2; single 201 sample between 150s → stays LOCKED, oERR_CNT=1.
- Boundaries: iCLK_CNT=100 and 200 → in window; 99 → error; iCNT_MIN=300, iCNT_MAX=200 → never locks.
- iCLK_CNT=0 → oCLK_DEAD=1 after tick, error counted; back to 150 → oCLK_DEAD=0 next tick.
- Force 0xFFFF errors then one more → oERR_CNT stays 0xFFFF; iCLR same cycle as error tick → 0.
- With macro, samples 120,180,110 → MIN_SEEN=110, MAX_SEEN=180; rst_n low mid-ACQUIRE → all outputs reset values asynchronously.
